// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler: time-division multiplexes N_NEURONS virtual LIF neurons onto a single
// external combinational neuron datapath. Each timestep walks neuron 0..N_NEURONS-1, one per
// cycle, feeding the shared latched input spike vector plus that neuron's stored state to the
// datapath and writing the results back.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   cfg_valid/ready      config write handshake (accepted only when idle)
//   cfg_addr             {neuron index, field}; field 0 weights, 1 threshold, 2 shift, 3 clear
//   cfg_data             write data, LSB-aligned, truncated to the field width
//   in_valid/ready       timestep start handshake; in_spikes latched on acceptance
//   out_valid/ready      timestep result handshake; out_spikes bit i = neuron i spike
//   busy                 high whenever not idle
//   dp_*                 drive / return of the shared neuron datapath
module lif_tdm_scheduler #(
  parameter int unsigned N_STAGES  = 2,
  parameter int unsigned N_NEURONS = 4,
  localparam int unsigned INPUTS   = 2 ** N_STAGES,
  localparam int unsigned MEM_W    = N_STAGES + 2,
  localparam int unsigned IDX_W    = $clog2(N_NEURONS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [IDX_W+1:0]        cfg_addr,
  input  logic [7:0]              cfg_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUTS-1:0]       in_spikes,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_NEURONS-1:0]    out_spikes,
  output logic                    busy,
  output logic [INPUTS-1:0]       dp_inputs,
  output logic [INPUTS-1:0]       dp_weights,
  output logic [2:0]              dp_shift,
  output logic [MEM_W-1:0]        dp_threshold,
  output logic signed [MEM_W-1:0] dp_last_membrane,
  output logic                    dp_was_spike,
  input  logic signed [MEM_W-1:0] dp_new_membrane,
  input  logic                    dp_spike
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  // Per-neuron state
  logic [INPUTS-1:0]       weights_q   [N_NEURONS];
  logic [MEM_W-1:0]        threshold_q [N_NEURONS];
  logic [2:0]              shift_q     [N_NEURONS];
  logic signed [MEM_W-1:0] membrane_q  [N_NEURONS];
  logic                    was_spike_q [N_NEURONS];

  // Timestep control
  logic [INPUTS-1:0]    inputs_q;
  logic [IDX_W-1:0]     idx_q;
  logic [N_NEURONS-1:0] out_spikes_q;
  logic                 out_valid_q, out_valid_d;

  logic             cfg_fire;
  logic             start;
  logic             last_idx;
  logic [1:0]       cfg_field;
  logic [IDX_W-1:0] cfg_nid;
  logic [31:0]      cfg_ext;
  logic [IDX_W-1:0] dp_sel;
  logic             unused_cfg;

  assign cfg_field  = cfg_addr[1:0];
  assign cfg_nid    = cfg_addr[IDX_W+1:2];
  // Zero-extend so every field slice below is in range regardless of parameters.
  assign cfg_ext    = {24'd0, cfg_data};
  assign unused_cfg = ^cfg_ext;

  // Config wins over a simultaneous timestep start.
  assign cfg_fire = (state_q == StIdle) && cfg_valid;
  assign start    = (state_q == StIdle) && in_valid && !cfg_valid;
  assign last_idx = (idx_q == IDX_W'(N_NEURONS - 1));

  // ---------------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_idx) state_d = StDone;
      StDone:  if (out_valid_q && out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // out_valid rises on the first edge spent in DONE and drops on the handshake edge.
  assign out_valid_d = (state_q == StDone) && !(out_valid_q && out_ready);

  // ---------------------------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    cfg_ready  = (state_q == StIdle);
    in_ready   = (state_q == StIdle) && !cfg_valid;
    busy       = (state_q != StIdle);
    out_valid  = out_valid_q;
    out_spikes = out_spikes_q;
    // Outside RUN the datapath sees neuron 0; its result is not written back.
    dp_sel           = (state_q == StRun) ? idx_q : '0;
    dp_inputs        = inputs_q;
    dp_weights       = weights_q[dp_sel];
    dp_shift         = shift_q[dp_sel];
    dp_threshold     = threshold_q[dp_sel];
    dp_last_membrane = membrane_q[dp_sel];
    dp_was_spike     = was_spike_q[dp_sel];
  end

  // ---------------------------------------------------------------------------------------------
  // Per-neuron registers: config writes when idle, datapath write-back in RUN
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        weights_q[i]   <= '1;
        threshold_q[i] <= MEM_W'(5);
        shift_q[i]     <= '0;
        membrane_q[i]  <= '0;
        was_spike_q[i] <= 1'b0;
      end
    end else begin
      if (cfg_fire) begin
        unique case (cfg_field)
          2'd0: weights_q[cfg_nid]   <= cfg_ext[INPUTS-1:0];
          2'd1: threshold_q[cfg_nid] <= cfg_ext[MEM_W-1:0];
          2'd2: shift_q[cfg_nid]     <= cfg_ext[2:0];
          2'd3: begin
            membrane_q[cfg_nid]  <= '0;
            was_spike_q[cfg_nid] <= 1'b0;
          end
          default: ;
        endcase
      end
      if (state_q == StRun) begin
        // Stored verbatim; any overflow behaviour belongs to the datapath.
        membrane_q[idx_q]  <= dp_new_membrane;
        was_spike_q[idx_q] <= dp_spike;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Timestep control registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inputs_q     <= '0;
      idx_q        <= '0;
      out_spikes_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (start) begin
        inputs_q     <= in_spikes;
        idx_q        <= '0;
        out_spikes_q <= '0;
      end else if (state_q == StRun) begin
        out_spikes_q[idx_q] <= dp_spike;
        idx_q               <= last_idx ? '0 : idx_q + 1'b1;
      end
    end
  end

endmodule
